addr_seq_arb: RTL and testbench

- Byte-serial sequencer and two-port arbiter for one shared external 8-bit full-adder datapath (sum/carry-out from a, b, carry-in).
- Performs NBYTES-wide additions by feeding the adder one byte per cycle, LSB first, and chaining the carry in an internal register.
- Two requesters share the adder under round-robin arbitration. The block sits between client logic and the single adder instance.

---
 rtl/addr_seq_arb.sv | 140 ++++++++++++++
 tb/tb_addr_seq_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/addr_seq_arb.sv
// addr_seq_arb: round-robin two-port sequencer feeding NBYTES-wide adds through one shared byte adder.
// Optional OVERFLOW_FLAG_EN adds a two's-complement overflow output ovf.
module addr_seq_arb #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [8*NBYTES-1:0]   a0,
  input  logic [8*NBYTES-1:0]   b0,
  input  logic                  cin0,
  input  logic                  req1,
  input  logic [8*NBYTES-1:0]   a1,
  input  logic [8*NBYTES-1:0]   b1,
  input  logic                  cin1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
`ifdef OVERFLOW_FLAG_EN
  output logic                  ovf,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic          carry_q, carry_d, rr_q, rr_d, id_q, id_d, cout_q, cout_d;
  logic          win, run;
`ifdef OVERFLOW_FLAG_EN
  logic          sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif
  // rr_q names the requester preferred on a tie
  assign win     = (req0 && req1) ? rr_q : req1;
  assign run     = state_q == RUN;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign gnt0    = run && idx_q == '0 && !id_q;
  assign gnt1    = run && idx_q == '0 && id_q;
  assign done_id = id_q;
  assign result  = res_q;
  assign cout    = cout_q;
  assign add_a   = run ? opa_q[7:0] : 8'd0;
  assign add_b   = run ? opb_q[7:0] : 8'd0;
  assign add_cin = run && carry_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf     = ovf_q;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = RUN;
        idx_d   = '0;
        opa_d   = win ? a1 : a0;
        opb_d   = win ? b1 : b0;
        carry_d = win ? cin1 : cin0;
        id_d    = win;
        rr_d    = !win;
`ifdef OVERFLOW_FLAG_EN
        sa_d    = win ? a1[W-1] : a0[W-1];
        sb_d    = win ? b1[W-1] : b0[W-1];
`endif
      end
      // operands shift down and the result fills from the top, so byte idx is always at bit 0
      RUN: begin
        opa_d   = opa_q >> 8;
        opb_d   = opb_q >> 8;
        res_d   = {add_sum, res_q[W-1:8]};
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          cout_d  = add_cout;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = (sa_q == sb_q) && (add_sum[7] != sa_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_addr_seq_arb.sv
// tb_addr_seq_arb: directed checks of addr_seq_arb with a behavioural byte adder attached.
module tb_addr_seq_arb;
  localparam int NB = 4;
  localparam int W  = 8 * NB;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, busy, done, done_id, cout, add_cin, add_cout;
  logic [W-1:0] result;
  logic [7:0] add_a, add_b, add_sum;
`ifdef OVERFLOW_FLAG_EN
  logic ovf;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  addr_seq_arb #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .cout(cout),
`ifdef OVERFLOW_FLAG_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit c,
                       input logic [W-1:0] er, input bit ec, input bit cin_chk);
    int n;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; cin1 = c; end
    else begin req0 = 1'b1; a0 = a; b0 = b; cin0 = c; end
    @(negedge clk);
    chk("op_gnt", id ? gnt1 : gnt0, 1);
    chk("op_gnt_other", id ? gnt0 : gnt1, 0);
    chk("op_busy", busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (cin_chk) chk("op_add_cin", add_cin, 1);
      @(negedge clk);
      n++;
      if (n == 1) chk("op_gnt_pulse", gnt0 | gnt1, 0);
    end
    chk("op_latency", n, NB);
    chk("op_result", result, er);
    chk("op_cout", cout, ec);
    chk("op_done_id", done_id, id);
    chk("op_busy_done", busy, 1);
    @(negedge clk);
    chk("op_idle", {busy, done}, 0);
    chk("op_result_hold", result, er);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int g, last, dn;
    bit gid;
    @(negedge clk);
    chk("rst_ctl", {gnt0, gnt1, busy, done, done_id, cout, add_cin}, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctl", {gnt0, gnt1, busy, done, done_id, cout, add_cin}, 0);
      chk("idle_add", {add_a, add_b}, 0);
      chk("idle_result", result, 0);
    end
    do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    do_reset();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; cin0 = 1'b0;
    req1 = 1'b1; a1 = 32'd3; b1 = 32'd4; cin1 = 1'b0;
    g = 0; last = 0; gid = 1'b0;
    for (int cyc = 0; cyc < 60 && g < 4; cyc++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("rr_both", 1, 0);
      if (done) begin
        chk("rr_done_id", done_id, gid);
        chk("rr_result", result, gid ? 32'd7 : 32'd3);
        chk("rr_no_gnt_in_done", gnt0 | gnt1, 0);
      end
      if (gnt0 || gnt1) begin
        chk("rr_order", gnt1, g[0]);
        if (g > 0) chk("rr_spacing", cyc - last, NB + 2);
        last = cyc;
        gid = gnt1;
        g++;
      end
    end
    chk("rr_count", g, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("rr_drain", busy, 0);
    req0 = 1'b1; a0 = 32'hAAAA_AAAA; b0 = 32'h5555_5555; cin0 = 1'b1;
    @(negedge clk);
    chk("mid_gnt", gnt0, 1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {gnt0, gnt1, busy, done, done_id, cout, add_cin}, 0);
    chk("mid_rst_add", {add_a, add_b}, 0);
    chk("mid_rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_no_done", dn, 0);
    do_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
`ifdef OVERFLOW_FLAG_EN
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1);
    do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    chk("ovf_clear", ovf, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
